// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register heap with pending-write scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int NUM_RD    = 2;
    localparam int NUM_WR    = 2;
    localparam int DEPTH     = 2 ** ADDR_W;
    // Widest pending vector popcount() accepts; narrower vectors are zero-extended.
    localparam int MAX_DEPTH = 1024;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            cnt += int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array select, register-0 masking and, with
// REGFILE_BYPASS_EN defined, forwarding of same-cycle write-back data.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int NUM_WR_P = NUM_WR
) (
    input  logic [ADDR_W_P-1:0]               ra,
    input  logic [2**ADDR_W_P-1:0][DATA_W_P-1:0] heap,
    input  logic [2**ADDR_W_P-1:0]            pend_vec,
`ifdef REGFILE_BYPASS_EN
    input  logic [NUM_WR_P-1:0]               regwr,
    input  logic [NUM_WR_P*ADDR_W_P-1:0]      rw,
    input  logic [NUM_WR_P*DATA_W_P-1:0]      busw,
    input  logic                              issue_en,
    input  logic [ADDR_W_P-1:0]               issue_rd,
`endif
    output logic [DATA_W_P-1:0]               busr,
    output logic                              pendr
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        busr  = heap[ra];
        pendr = pend_vec[ra];
`ifdef REGFILE_BYPASS_EN
        // Ascending scan: the highest-index matching port wins, as in the array write.
        for (int w = 0; w < NUM_WR_P; w++) begin
            if (regwr[w] && (rw[w*ADDR_W_P +: ADDR_W_P] == ra)) begin
                busr  = busw[w*DATA_W_P +: DATA_W_P];
                pendr = issue_en && (issue_rd == ra);
            end
        end
`endif
        if (ra == '0) begin
            busr  = '0;
            pendr = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register heap with pending-write scoreboard for RAW hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN (read ports forward same-cycle write data).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int NUM_RD_P = NUM_RD,
    parameter int NUM_WR_P = NUM_WR
) (
    input  logic                              WrClk,
    input  logic                              RstN,
    input  logic [NUM_RD_P*ADDR_W_P-1:0]      Ra,
    output logic [NUM_RD_P*DATA_W_P-1:0]      busR,
    output logic [NUM_RD_P-1:0]               PendR,
    input  logic [NUM_WR_P-1:0]               RegWr,
    input  logic [NUM_WR_P*ADDR_W_P-1:0]      Rw,
    input  logic [NUM_WR_P*DATA_W_P-1:0]      busW,
    input  logic                              IssueEn,
    input  logic [ADDR_W_P-1:0]               IssueRd,
    output logic [$clog2(2**ADDR_W_P+1)-1:0]  PendCount
);

    localparam int DEPTH_P = 2 ** ADDR_W_P;
    localparam int CNT_W   = $clog2(DEPTH_P + 1);

    logic [DEPTH_P-1:0][DATA_W_P-1:0] heap, heap_nxt;
    logic [DEPTH_P-1:0]               pending, pend_nxt;
    logic [NUM_WR_P-1:0]              wr_en;
    logic                             issue_en;

    // Requests are dead while reset is held, including on the bypass path.
    assign wr_en    = RegWr & {NUM_WR_P{RstN}};
    assign issue_en = IssueEn & RstN;

    always_comb begin
        heap_nxt = heap;
        pend_nxt = pending;
        for (int w = 0; w < NUM_WR_P; w++) begin
            if (wr_en[w] && (Rw[w*ADDR_W_P +: ADDR_W_P] != '0)) begin
                heap_nxt[Rw[w*ADDR_W_P +: ADDR_W_P]] = busW[w*DATA_W_P +: DATA_W_P];
                pend_nxt[Rw[w*ADDR_W_P +: ADDR_W_P]] = 1'b0;
            end
        end
        // Applied after the clears: the newly issued producer is still outstanding.
        if (issue_en && (IssueRd != '0)) begin
            pend_nxt[IssueRd] = 1'b1;
        end
    end

    // NOTE: the whole heap is in the async reset; register contents must read 0 immediately on reset.
    always_ff @(posedge WrClk or negedge RstN) begin
        if (!RstN) begin
            heap      <= '0;
            pending   <= '0;
            PendCount <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            heap      <= heap_nxt;
            pending   <= pend_nxt;
            PendCount <= CNT_W'(popcount(MAX_DEPTH'(pend_nxt)));
        end
    end

    for (genvar k = 0; k < NUM_RD_P; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W_P (DATA_W_P),
            .ADDR_W_P (ADDR_W_P),
            .NUM_WR_P (NUM_WR_P)
        ) u_rd (
            .ra       (Ra[k*ADDR_W_P +: ADDR_W_P]),
            .heap     (heap),
            .pend_vec (pending),
`ifdef REGFILE_BYPASS_EN
            .regwr    (wr_en),
            .rw       (Rw),
            .busw     (busW),
            .issue_en (issue_en),
            .issue_rd (IssueRd),
`endif
            .busr     (busR[k*DATA_W_P +: DATA_W_P]),
            .pendr    (PendR[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (both with and without REGFILE_BYPASS_EN).
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic                     WrClk;
    logic                     RstN;
    logic [2*ADDR_W-1:0]      Ra;
    logic [2*DATA_W-1:0]      busR;
    logic [1:0]               PendR;
    logic [1:0]               RegWr;
    logic [2*ADDR_W-1:0]      Rw;
    logic [2*DATA_W-1:0]      busW;
    logic                     IssueEn;
    reg_addr_t                IssueRd;
    logic [5:0]               PendCount;

    int n_pass  = 0;
    int n_check = 0;

    regfile_scoreboard dut (
        .WrClk     (WrClk),
        .RstN      (RstN),
        .Ra        (Ra),
        .busR      (busR),
        .PendR     (PendR),
        .RegWr     (RegWr),
        .Rw        (Rw),
        .busW      (busW),
        .IssueEn   (IssueEn),
        .IssueRd   (IssueRd),
        .PendCount (PendCount)
    );

    initial WrClk = 1'b0;
    always #5 WrClk = ~WrClk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        RegWr   = 2'b00;
        IssueEn = 1'b0;
        IssueRd = '0;
    endtask

    task automatic wr0(input reg_addr_t a, input reg_data_t d);
        RegWr[0]      = 1'b1;
        Rw[4:0]       = a;
        busW[31:0]    = d;
    endtask

    task automatic wr1(input reg_addr_t a, input reg_data_t d);
        RegWr[1]      = 1'b1;
        Rw[9:5]       = a;
        busW[63:32]   = d;
    endtask

    task automatic issue(input reg_addr_t a);
        IssueEn = 1'b1;
        IssueRd = a;
    endtask

    task automatic rd(input reg_addr_t a0, input reg_addr_t a1);
        Ra = {a1, a0};
        #1;
    endtask

    // Apply the staged requests at the next edge, then return to idle 1 time unit later.
    task automatic clk();
        @(posedge WrClk);
        #1;
        idle();
    endtask

    initial begin
        RstN = 1'b0;
        Ra   = '0;
        Rw   = '0;
        busW = '0;
        idle();
        #2;
        rd(5'd5, 5'd7);
        check("reset_busr", {32'b0, busR[31:0]}, 64'h0);
        check("reset_cnt", {58'b0, PendCount}, 64'd0);
        @(negedge WrClk);
        RstN = 1'b1;
        clk();

        // Reset mid-operation
        wr0(5'd5, 32'hDEADBEEF);
        issue(5'd7);
        clk();
        rd(5'd5, 5'd7);
        check("pre_rst_busr5", {32'b0, busR[31:0]}, 64'hDEADBEEF);
        check("pre_rst_pend7", {63'b0, PendR[1]}, 64'd1);
        check("pre_rst_cnt", {58'b0, PendCount}, 64'd1);
        RstN = 1'b0;
        #1;
        check("rst_busr5", {32'b0, busR[31:0]}, 64'h0);
        check("rst_pend7", {63'b0, PendR[1]}, 64'd0);
        check("rst_cnt", {58'b0, PendCount}, 64'd0);
        wr0(5'd5, 32'h1);
        issue(5'd7);
        clk();
        rd(5'd5, 5'd7);
        check("rst_hold_wr", {32'b0, busR[31:0]}, 64'h0);
        check("rst_hold_iss", {63'b0, PendR[1]}, 64'd0);
        RstN = 1'b1;

        // Register 0
        clk();
        wr0(5'd0, 32'hFFFFFFFF);
        wr1(5'd0, 32'hFFFFFFFF);
        issue(5'd0);
        clk();
        rd(5'd0, 5'd0);
        check("r0_busr", {32'b0, busR[31:0]}, 64'h0);
        check("r0_pendr", {63'b0, PendR[0]}, 64'd0);
        check("r0_cnt", {58'b0, PendCount}, 64'd0);

        // Scoreboard issue then clear
        issue(5'd3);
        clk();
        rd(5'd3, 5'd0);
        check("sb_pend3", {63'b0, PendR[0]}, 64'd1);
        check("sb_cnt1", {58'b0, PendCount}, 64'd1);
        wr1(5'd3, 32'h12);
        clk();
        rd(5'd3, 5'd0);
        check("sb_busr3", {32'b0, busR[31:0]}, 64'h12);
        check("sb_clear3", {63'b0, PendR[0]}, 64'd0);
        check("sb_cnt0", {58'b0, PendCount}, 64'd0);

        // Write conflict, and issue + write to the same register
        wr0(5'd9, 32'h11);
        wr1(5'd9, 32'h22);
        clk();
        rd(5'd9, 5'd0);
        check("conf_r9", {32'b0, busR[31:0]}, 64'h22);
        check("conf_pend9", {63'b0, PendR[0]}, 64'd0);
        issue(5'd4);
        wr0(5'd4, 32'h55);
        clk();
        rd(5'd9, 5'd4);
        check("iw_r4", {32'b0, busR[63:32]}, 64'h55);
        check("iw_pend4", {63'b0, PendR[1]}, 64'd1);
        check("iw_cnt", {58'b0, PendCount}, 64'd1);

        // Same-cycle write to a pending register: forwarded only with bypass
        wr1(5'd4, 32'hABCD);
        rd(5'd4, 5'd9);
`ifdef REGFILE_BYPASS_EN
        check("byp_busr", {32'b0, busR[31:0]}, 64'hABCD);
        check("byp_pendr", {63'b0, PendR[0]}, 64'd0);
`else
        check("nobyp_busr", {32'b0, busR[31:0]}, 64'h55);
        check("nobyp_pendr", {63'b0, PendR[0]}, 64'd1);
`endif
        clk();
        rd(5'd4, 5'd9);
        check("post_wr_r4", {32'b0, busR[31:0]}, 64'hABCD);
        check("post_wr_pend4", {63'b0, PendR[0]}, 64'd0);
        check("post_wr_cnt", {58'b0, PendCount}, 64'd0);

        // Same-cycle issue alone never shows on PendR
        issue(5'd8);
        rd(5'd8, 5'd9);
        check("iss_same_cyc", {63'b0, PendR[0]}, 64'd0);
        clk();
        check("iss_next_cyc", {63'b0, PendR[0]}, 64'd1);
        wr0(5'd8, 32'h0);
        clk();
        check("iss_cleared_cnt", {58'b0, PendCount}, 64'd0);

        // Fill the scoreboard
        for (int i = 1; i < 32; i++) begin
            issue(reg_addr_t'(i));
            clk();
            if (i == 16) check("fill_cnt16", {58'b0, PendCount}, 64'd16);
        end
        check("fill_cnt31", {58'b0, PendCount}, 64'd31);
        issue(5'd1);
        clk();
        check("reissue_cnt", {58'b0, PendCount}, 64'd31);
        wr0(5'd31, 32'h31);
        wr1(5'd30, 32'h30);
        issue(5'd1);
        clk();
        rd(5'd31, 5'd30);
        check("drain_cnt", {58'b0, PendCount}, 64'd29);
        check("drain_data", busR, {32'h30, 32'h31});
        check("drain_pend", {62'b0, PendR}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port register file with an integrated pending-write scoreboard, the next-generation register heap for the pipelined CPU. It provides NUM_RD combinational read ports and NUM_WR synchronous write-back ports, keeps register 0 hard-wired to zero, and tracks which registers have an issued-but-not-yet-written result so the issue stage can detect RAW hazards. It sits between decode/issue (read, issue) and write-back (write, clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (≥1)
- NUM_WR, 2, number of write-back ports (≥1)
- WrClk  in  1  clock; all state updates on rising edge
- RstN  in  1  reset, asynchronous, active-low
- Ra  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- busR  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- PendR  out  NUM_RD  pending flag of the register addressed by read port k
- RegWr  in  NUM_WR  write enable per write port
- Rw  in  NUM_WR*ADDR_W  write addresses
- busW  in  NUM_WR*DATA_W  write data
- IssueEn  in  1  mark IssueRd as pending
- IssueRd  in  ADDR_W  destination register being issued
- PendCount  out  $clog2(DEPTH+1)  number of registers currently pending

## Operation
- Storage: DEPTH × DATA_W array plus DEPTH-bit pending vector.
- Reset (RstN low): every register, every pending bit and PendCount are 0 immediately, independent of WrClk; writes and issues ignored while RstN is low. Deassertion takes effect at the next rising edge.
- Register 0: never written, never pending; busR reads 0 and PendR reads 0 for address 0 regardless of writes/issues.
- Write: on each edge, for each port w with RegWr[w]=1 and Rw≠0, heap[Rw] ← busW and pending[Rw] ← 0.
- Write conflict: two or more ports to the same address in one cycle → highest-index port's data is stored; pending cleared.
- Issue: IssueEn=1 and IssueRd≠0 → pending[IssueRd] ← 1 at the edge.
- Issue + write to same register in same cycle → issue wins: data stored, pending stays/becomes 1 (the newer producer is outstanding).
- Issue to an already-pending register → stays 1, PendCount unchanged.
- Write to a non-pending register is legal: data stored, pending stays 0.
- PendCount: registered; after each edge equals popcount of the pending vector just written. Range 0..DEPTH-1.
- Read: busR/PendR are combinational from Ra and current state (plus bypass, see Configuration).

## Timing
- Read latency 0 cycles (combinational).
- Write and issue visible to reads 1 cycle later (next edge) without bypass.
- PendCount reflects an edge's issues/clears in the same cycle as the pending vector (1 cycle after request).
- No handshake; all requests accepted every cycle. Caller must not issue when it cannot stall on PendR.

## Configuration
- REGFILE_BYPASS_EN defined: each read port forwards same-cycle write data combinationally — if any RegWr[w] with Rw[w]=Ra[k]≠0, busR[k] = busW of the highest such w, and PendR[k] = 0 unless IssueEn with IssueRd=Ra[k] is also active (then 1). Same-cycle issue alone does not set PendR.
- Not defined: reads return stored array/pending state only; no combinational path from write or issue ports to read outputs.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W/NUM_RD/NUM_WR constants, typedefs reg_addr_t and reg_data_t, and a popcount function for PendCount.
- Sub-module regfile_rd_port: one read port (array select, zero-register masking, optional bypass mux), instantiated NUM_RD times via generate.

## Test plan
- Reset mid-operation: write heap[5]=0xDEADBEEF, issue r7, pulse RstN low between edges -> busR(5)=0, PendR(7)=0, PendCount=0 immediately.
- Register 0: RegWr to Rw=0 with 0xFFFFFFFF, IssueEn IssueRd=0 -> Ra=0 reads 0, PendR=0, PendCount unchanged.
- Scoreboard: issue r3 -> next cycle PendR(3)=1, PendCount=1; write r3=0x12 -> next cycle PendR(3)=0, busR=0x12, PendCount=0.
- Conflict: port0 writes r9=0x11, port1 writes r9=0x22 same cycle -> r9 reads 0x22; issue r4 and write r4=0x55 same cycle -> r4=0x55, PendR(4)=1.
- Fill: issue r1..r31 on consecutive cycles -> PendCount reaches 31; re-issue r1 -> stays 31.
- Bypass (REGFILE_BYPASS_EN): pending r6, write r6=0xABCD while Ra=6 -> busR=0xABCD and PendR=0 same cycle; without macro -> old value and PendR=1 that cycle.
